fpadd_issue: RTL and testbench
==============================

# fpadd_issue

Request-side sequencer for the multi-cycle single-precision floating-point adder. Accepts operand pairs on a valid/ready stream, buffers them in a small FIFO, drives the adder's level `start` / `done` handshake one operation at a time, and returns each result on a valid/ready output stream. Sits between the datapath issuing FP add/sub requests and the adder instance, so callers never deal with the adder's multi-cycle protocol.

## Interface
- `DEPTH`, 4: operand FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 512: WAIT-state cycle limit; only used when the watchdog is compiled in.

- `clk` in 1: sole clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: equals !full.
- `in_a` in 32: IEEE-754 operand A.
- `in_b` in 32: IEEE-754 operand B.
- `in_sub` in 1: 1 = A−B; B's bit 31 is inverted on push.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out_sum` out 32: result word.
- `out_timeout` out 1: result produced by the watchdog, not by the adder.
- `add_start` out 1: to adder `start`.
- `add_a` out 32: to adder `a`.
- `add_b` out 32: to adder `b`.
- `add_sum` in 32: from adder `sum`.
- `add_done` in 1: from adder `done`.

## Operation
- FIFO: push on `in_valid && in_ready`; pop on the IDLE→START transition. Push and pop in the same cycle leave the count unchanged. No push when full. The count wraps modulo DEPTH via pointer bits plus one extra bit.
- FSM states: IDLE, START, ARM, WAIT, OUT.
  - IDLE: if FIFO is non-empty, load `add_a` / `add_b` from the head, pop, and go to START.
  - START: `add_start`=1 for exactly this cycle; go to ARM.
  - ARM: `add_start`=0; `add_done` is ignored. This covers the adder's stale `done` from a previous operation or from reset. Go to WAIT.
  - WAIT: on `add_done`=1, register `add_sum` into `out_sum`, set `out_timeout`=0 and `out_valid`=1, and go to OUT.
  - OUT: hold `out_valid`, `out_sum` and `out_timeout` until `out_ready`=1. Then clear `out_valid` and go to IDLE.
- `add_a` and `add_b` stay stable from START until the next IDLE→START load.
- Only one operation is in flight; results return in push order.
- Reset mid-operation: the FIFO is emptied, the state goes to IDLE, and the in-flight result is discarded. The same `reset` must drive the adder instance.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_timeout`=0, `add_start`=0, `add_a`=0, `add_b`=0. The FIFO is empty.
- Push in cycle 0 into an empty, idle block: `add_start` is high in cycle 2, and the adder sees start-low from cycle 3.
- `out_valid` rises the cycle after `add_done` is first sampled high in WAIT.
- For 1.0+1.0 on the current adder, `out_valid` first rises in cycle 11.
- Throughput: one operation per (adder latency + 4) cycles when `out_ready` is held high.
- If `out_ready` is already high on entry to OUT, OUT lasts one cycle.

## Configuration
- `FPADD_ISSUE_TIMEOUT_EN` defined: a WAIT-cycle counter is compiled in. It clears on entry to WAIT.
  - If the counter reaches `TIMEOUT_CYCLES` without `add_done`, the block enters OUT with `out_sum`=32'h7FC00000 (qNaN) and `out_timeout`=1.
  - A late `add_done` is ignored because the next operation passes through ARM.
- Not defined: no counter. WAIT lasts indefinitely and `out_timeout` is tied to 0.

## Test plan
- Push a=32'h3F800000, b=32'h3F800000, `in_sub`=0 with `out_ready`=1. Expect `add_start` high in cycle 2 only, then `out_sum`=32'h40000000 with `out_timeout`=0.
- Push a=32'h3F800000, b=32'h3F800000, `in_sub`=1. Expect `add_b`=32'hBF800000 and `out_sum`=32'h00000000.
- Hold `out_ready`=0 and push 5 pairs with DEPTH=4. Expect `in_ready`=0 after the FIFO fills. Expect `out_valid` and `out_sum` held stable. Releasing `out_ready` drains all 5 results in push order.
- With `FPADD_ISSUE_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=16, and `add_done` tied low: expect `out_sum`=32'h7FC00000 and `out_timeout`=1. Without the macro, `out_valid` never rises.
- Pre-set `add_done`=1 (stale) and push a pair. Expect no capture in ARM; the result is taken only after the adder's new `done`.
- Assert `reset` in WAIT with 2 entries queued. Next cycle: `in_ready`=1, `out_valid`=0, `add_start`=0. The queued entries are never issued.

Source files
------------

// File: rtl/fpadd_issue.sv
// fpadd_issue: request-side sequencer for the multi-cycle single-precision adder.
// Buffers operand pairs in a small FIFO, runs the adder's level start/done handshake
// one operation at a time and returns results on a valid/ready stream.
// Optional WAIT-state watchdog: define FPADD_ISSUE_TIMEOUT_EN.
module fpadd_issue #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 512
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_a_i,
  input  logic [31:0] in_b_i,
  input  logic        in_sub_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_sum_o,
  output logic        out_timeout_o,
  output logic        add_start_o,
  output logic [31:0] add_a_o,
  output logic [31:0] add_b_o,
  input  logic [31:0] add_sum_i,
  input  logic        add_done_i
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  typedef enum logic [2:0] {StIdle, StStart, StArm, StWait, StOut} state_e;

  state_e      state_q;
  logic [63:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        full, empty, push, pop;
  logic [63:0] head;
  logic        add_start_q, out_valid_q;
  logic [31:0] add_a_q, add_b_q, out_sum_q;

  // Extra pointer bit tells full from empty when the index bits match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = in_valid_i && !full;
  assign pop   = (state_q == StIdle) && !empty;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign in_ready_o  = !full;
  assign add_start_o = add_start_q;
  assign add_a_o     = add_a_q;
  assign add_b_o     = add_b_q;
  assign out_valid_o = out_valid_q;
  assign out_sum_o   = out_sum_q;

  // Operand storage; subtraction is folded in by flipping B's sign on the way in.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_a_i, in_b_i ^ {in_sub_i, 31'b0}};
    end
  end

  // FIFO pointers; a push and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

`ifdef FPADD_ISSUE_TIMEOUT_EN
  localparam int unsigned TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] QNaN    = 32'h7FC00000;

  logic [TW-1:0] tmr_q;
  logic          out_timeout_q;

  assign out_timeout_o = out_timeout_q;
`else
  logic unused_cfg;

  assign out_timeout_o = 1'b0;
  assign unused_cfg    = ^TIMEOUT_CYCLES;
`endif

  // Issue FSM with registered adder-side and result-side outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      add_start_q   <= 1'b0;
      add_a_q       <= '0;
      add_b_q       <= '0;
      out_valid_q   <= 1'b0;
      out_sum_q     <= '0;
`ifdef FPADD_ISSUE_TIMEOUT_EN
      tmr_q         <= '0;
      out_timeout_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            add_a_q     <= head[63:32];
            add_b_q     <= head[31:0];
            add_start_q <= 1'b1;
            state_q     <= StStart;
          end
        end
        StStart: begin
          add_start_q <= 1'b0;
          state_q     <= StArm;
        end
        // done is still stale here (previous op or reset), so it is not looked at.
        StArm: begin
`ifdef FPADD_ISSUE_TIMEOUT_EN
          tmr_q <= '0;
`endif
          state_q <= StWait;
        end
        StWait: begin
          if (add_done_i) begin
            out_sum_q     <= add_sum_i;
            out_valid_q   <= 1'b1;
`ifdef FPADD_ISSUE_TIMEOUT_EN
            out_timeout_q <= 1'b0;
`endif
            state_q       <= StOut;
`ifdef FPADD_ISSUE_TIMEOUT_EN
          end else if (tmr_q == TmoLast) begin
            out_sum_q     <= QNaN;
            out_valid_q   <= 1'b1;
            out_timeout_q <= 1'b1;
            state_q       <= StOut;
          end else begin
            tmr_q <= tmr_q + 1'b1;
`endif
          end
        end
        StOut: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fpadd_issue.sv
// Bench for fpadd_issue: behavioural multi-cycle adder stub plus a scoreboard that
// predicts issued operands and results from integer-valued float arithmetic.
module tb_fpadd_issue;

  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 16;
  localparam logic [31:0] QNaN  = 32'h7FC00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_sub = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        out_valid, out_ready = 1'b1, out_timeout;
  logic [31:0] out_sum;
  logic        add_start, add_done;
  logic [31:0] add_a, add_b, add_sum;
  logic        stale = 1'b0, kill = 1'b0;

  int n_tot = 0;
  int n_bad = 0;
  int cyc = 0;
  int push_cyc = 0;

  logic [31:0] iss_a[$], iss_b[$], exp_sum[$];
  logic        exp_to[$];
  logic        hold_q = 1'b0, hold_to = 1'b0;
  logic [31:0] hold_sum = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpadd_issue #(.DEPTH(Depth), .TIMEOUT_CYCLES(Tmo)) dut (
    .clk_i(clk), .reset_i(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b), .in_sub_i(in_sub),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_sum_o(out_sum), .out_timeout_o(out_timeout),
    .add_start_o(add_start), .add_a_o(add_a), .add_b_o(add_b),
    .add_sum_i(add_sum), .add_done_i(add_done)
  );

  function automatic logic [31:0] i2f(input int v);
    int m, p;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 31; i++) if (((m >> i) & 1) != 0) p = i;
    return {v < 0, 8'(127 + p), 23'(m << (23 - p))};
  endfunction

  function automatic int f2i(input logic [31:0] f);
    int e, m;
    e = int'(f[30:23]);
    if (e == 0) return 0;
    m = int'({9'b0, 1'b1, f[22:0]}) >> (150 - e);
    return f[31] ? -m : m;
  endfunction

  // Adder stub: 7 cycles from sampled start to done; done stays high until one
  // cycle after the next start, so the sequencer's ARM cycle sees it stale.
  int          stub_cnt_q = 0;
  logic        stub_done_q = 1'b0, stub_clr_q = 1'b0;
  logic [31:0] stub_res_q = '0, stub_sum_q = '0;
  always @(posedge clk) begin
    if (reset) begin
      stub_cnt_q  <= 0;
      stub_done_q <= 1'b0;
      stub_clr_q  <= 1'b0;
      stub_res_q  <= '0;
      stub_sum_q  <= '0;
    end else begin
      stub_clr_q <= add_start;
      if (stub_clr_q) stub_done_q <= 1'b0;
      if (add_start) begin
        stub_cnt_q <= 7;
        stub_res_q <= i2f(f2i(add_a) + f2i(add_b));
      end else if (stub_cnt_q != 0) begin
        stub_cnt_q <= stub_cnt_q - 1;
        if (stub_cnt_q == 1) begin
          stub_done_q <= 1'b1;
          stub_sum_q  <= stub_res_q;
        end
      end
    end
  end
  assign add_done = (stub_done_q | stale) & ~kill;
  assign add_sum  = stub_sum_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitors: issued operands, held outputs and delivered results.
  always @(negedge clk) begin
    if (!reset) begin
      if (add_start) begin
        if (iss_a.size() == 0) chk("spurious_start", {31'b0, add_start}, 32'h0);
        else begin
          chk("add_a", add_a, iss_a.pop_front());
          chk("add_b", add_b, iss_b.pop_front());
        end
      end
      if (hold_q) begin
        chk("hold_valid", {31'b0, out_valid}, 32'h1);
        chk("hold_sum", out_sum, hold_sum);
        chk("hold_to", {31'b0, out_timeout}, {31'b0, hold_to});
      end
      if (out_valid && out_ready) begin
        if (exp_sum.size() == 0) chk("spurious_out", {31'b0, out_valid}, 32'h0);
        else begin
          chk("out_sum", out_sum, exp_sum.pop_front());
          chk("out_timeout", {31'b0, out_timeout}, {31'b0, exp_to.pop_front()});
        end
      end
      hold_q   <= out_valid && !out_ready;
      hold_sum <= out_sum;
      hold_to  <= out_timeout;
    end else begin
      hold_q <= 1'b0;
    end
  end

  task automatic push_op(input int a, input int b, input bit sub);
    bit acc;
    acc = 1'b0;
    @(posedge clk); #1;
    in_a = i2f(a); in_b = i2f(b); in_sub = sub; in_valid = 1'b1;
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        push_cyc = cyc;
        iss_a.push_back(i2f(a));
        iss_b.push_back(i2f(b) ^ (sub ? 32'h8000_0000 : 32'h0));
        exp_sum.push_back(kill ? QNaN : i2f(sub ? a - b : a + b));
        exp_to.push_back(kill);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("push_timeout", {31'b0, acc}, 32'h1);
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_sum.size() != 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk("drain_left", exp_sum.size(), 32'h0);
  endtask

  // Cycle-exact check of start pulse and result timing for a lone operation.
  task automatic timed(input bit drop_stale, input logic [31:0] want);
    int k;
    k = 0;
    while (k < 14) begin
      @(negedge clk);
      k = cyc - push_cyc;
      chk($sformatf("start_k%0d", k), {31'b0, add_start}, {31'b0, k == 2});
      chk($sformatf("valid_k%0d", k), {31'b0, out_valid}, {31'b0, k == 11});
      if (k == 11) chk("timed_sum", out_sum, want);
      if (drop_stale && k == 3) begin
        @(posedge clk); #1;
        stale = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    iss_a.delete(); iss_b.delete(); exp_sum.delete(); exp_to.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit rand_done, seen;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_sum", out_sum, 32'h0);
    chk("rst_out_timeout", {31'b0, out_timeout}, 32'h0);
    chk("rst_add_start", {31'b0, add_start}, 32'h0);
    chk("rst_add_a", add_a, 32'h0);
    chk("rst_add_b", add_b, 32'h0);

    // 1.0 + 1.0 with cycle-exact timing
    push_op(1, 1, 1'b0);
    timed(1'b0, 32'h4000_0000);
    wait_drain(50);

    // 1.0 - 1.0
    push_op(1, 1, 1'b1);
    wait_drain(50);
    chk("sub_add_b", add_b, 32'hBF80_0000);

    // Stale done held through ARM must not be captured
    @(posedge clk); #1;
    stale = 1'b1;
    repeat (2) @(posedge clk);
    push_op(2, 3, 1'b0);
    timed(1'b1, i2f(5));
    wait_drain(50);

    // Fill with consumer stalled, then drain in order
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_op(i + 1, 10 * i - 7, i[0]);
    repeat (20) @(negedge clk);
    chk("full_in_ready", {31'b0, in_ready}, 32'h0);
    chk("full_out_valid", {31'b0, out_valid}, 32'h1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain(200);

    // Randomized traffic with random back-pressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          push_op(int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100,
                  1'($urandom_range(0, 1)));
        end
        rand_done = 1'b1;
      end
      begin
        for (int g = 0; g < 5000 && !(rand_done && exp_sum.size() == 0); g++) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain(200);

    // Adder never answers
    @(posedge clk); #1;
    kill = 1'b1;
    push_op(6, 1, 1'b0);
`ifdef FPADD_ISSUE_TIMEOUT_EN
    wait_drain(200);
    @(posedge clk); #1;
    kill = 1'b0;
    push_op(4, 9, 1'b1);
    wait_drain(200);
`else
    seen = 1'b0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_timeout_valid", {31'b0, seen}, 32'h0);
    kill = 1'b0;
    do_reset();
`endif

    // Reset while in WAIT with two entries queued
    push_op(3, 4, 1'b0);
    push_op(5, 6, 1'b0);
    push_op(7, 8, 1'b1);
    do_reset();
    @(negedge clk);
    chk("rst2_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst2_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst2_add_start", {31'b0, add_start}, 32'h0);
    seen = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (add_start || out_valid) seen = 1'b1;
    end
    chk("rst2_no_issue", {31'b0, seen}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
